l15_store_splitter: RTL
=======================

L15_STORE_SPLITTER -- requirements
Module: l15_store_splitter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, store data width (64 or 128).
REQ-002 SHALL have parameter ADDR_WIDTH, default 40, physical address width.
REQ-003 SHALL have parameter TID_WIDTH, default 3, L1.5 thread-ID width; pool of 2**TID_WIDTH IDs.
REQ-004 SHALL have ports:
- clk_i  in  1  clock; one clock only.
- rst_i  in  1  reset; synchronous, active-high.
- st_valid_i  in  1  store request valid.
- st_ready_o  out  1  store accepted when st_valid_i&&st_ready_o.
- st_addr_i  in  ADDR_WIDTH  store base address; low log2(DATA_WIDTH/8) bits ignored.
- st_data_i  in  DATA_WIDTH  store data.
- st_be_i  in  DATA_WIDTH/8  byte enables.
- req_val_o  out  1  L1.5 store request valid (rqtype store).
- req_ack_i  in  1  L1.5 request accepted.
- req_addr_o  out  ADDR_WIDTH  chunk address.
- req_size_o  out  3  size code 000/001/010/011 = 1/2/4/8 bytes.
- req_data_o  out  64  replicated chunk data.
- req_tid_o  out  TID_WIDTH  thread ID of the request.
- rtrn_val_i  in  1  L1.5 return valid.
- rtrn_type_i  in  4  return type; store ack = 4'b0100.
- rtrn_tid_i  in  TID_WIDTH  return thread ID.
- busy_o  out  1  FSM not IDLE or any ID outstanding.

Function
REQ-005 SHALL implement FSM IDLE, SEND, WAIT_TID.
REQ-006 st_ready_o SHALL be 1 only in IDLE; acceptance latches address, data, mask.
REQ-007 Accept with all-zero mask SHALL emit no request and stay IDLE.
REQ-008 Accept with non-zero mask SHALL go SEND if a free ID exists, else WAIT_TID; req_val_o rises the cycle after acceptance.
REQ-009 Each chunk SHALL be the largest naturally aligned 1/2/4/8-byte block starting at the lowest remaining set byte with all its bytes enabled.
REQ-010 req_addr_o SHALL be aligned base + chunk byte offset; req_size_o per REQ-004.
REQ-011 req_data_o SHALL replicate the chunk across 64 bits (byte x8, hword x4, word x2, dword as is).
REQ-012 req_val_o and all req_* fields SHALL hold stable until req_ack_i is sampled high.
REQ-013 On req_ack_i the chunk's bytes SHALL clear from the mask and the ID SHALL be marked outstanding; next chunk presented no earlier than the following cycle.
REQ-014 req_tid_o SHALL be the lowest-numbered free ID, sampled from the registered pool.
REQ-015 With no free ID in SEND the FSM SHALL go WAIT_TID with req_val_o low; returns to SEND the cycle after an ID frees.
REQ-016 rtrn_val_i with store-ack type SHALL free rtrn_tid_i; other types or non-outstanding IDs SHALL be ignored.
REQ-017 An ID freed in cycle N SHALL be allocatable no earlier than cycle N+1.
REQ-018 Mask empty after an ack SHALL return FSM to IDLE next cycle.

Reset
REQ-019 rst_i high at a clock edge SHALL force IDLE, clear mask and ID pool, drop in-flight chunks; outputs: st_ready_o=1, req_val_o=0, req_* =0, busy_o=0.

Configuration
REQ-020 Macro L15_SPLIT_STATS_EN defined SHALL add output stat_pkts_o, 32 bits, incremented per acked request, saturating at 0xFFFFFFFF, reset 0.
REQ-021 Without L15_SPLIT_STATS_EN the port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-022 64-bit, addr 0x1000, be 0xFF, immediate acks -> one request addr 0x1000 size 011 data unchanged tid 0.
REQ-023 64-bit, addr 0x1000, be 0x3C -> two requests: 0x1002 size 001, then 0x1004 size 001.
REQ-024 64-bit, be 0x01, data 0x..AB -> addr 0x1000 size 000 data 0xABABABABABABABAB.
REQ-025 TID_WIDTH=1, three be 0xFF stores, no returns -> tids 0,1 then WAIT_TID; store ack tid 0 -> third request tid 0 the cycle after.
REQ-026 DATA_WIDTH=128, addr 0x2000, be 0xFFFF -> requests 0x2000 and 0x2008, both size 011.
REQ-027 rst_i asserted while req_val_o=1 and req_ack_i=0 -> next cycle req_val_o=0, st_ready_o=1, busy_o=0.

Source files
------------

// File: rtl/l15_store_splitter.sv
// l15_store_splitter: splits masked stores into aligned L1.5 chunk requests; L15_SPLIT_STATS_EN adds stat_pkts_o
module l15_store_splitter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 40,
  parameter int TID_WIDTH = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    st_valid_i,
  output logic                    st_ready_o,
  input  logic [ADDR_WIDTH-1:0]   st_addr_i,
  input  logic [DATA_WIDTH-1:0]   st_data_i,
  input  logic [DATA_WIDTH/8-1:0] st_be_i,
  output logic                    req_val_o,
  input  logic                    req_ack_i,
  output logic [ADDR_WIDTH-1:0]   req_addr_o,
  output logic [2:0]              req_size_o,
  output logic [63:0]             req_data_o,
  output logic [TID_WIDTH-1:0]    req_tid_o,
  input  logic                    rtrn_val_i,
  input  logic [3:0]              rtrn_type_i,
  input  logic [TID_WIDTH-1:0]    rtrn_tid_i,
`ifdef L15_SPLIT_STATS_EN
  output logic [31:0]             stat_pkts_o,
`endif
  output logic                    busy_o
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LW = $clog2(NB);
  localparam int NT = 1 << TID_WIDTH;
  localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, WAIT_TID = 2'd2;

  logic [1:0] state, state_d;
  logic [ADDR_WIDTH-1:LW] base_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [NB-1:0] mask_q, chunk, mask_left;
  logic [NT-1:0] pool_q, fre, ack_bit, avail;
  logic [TID_WIDTH-1:0] tid_q, nfree;
  logic [LW-1:0] lo;
  logic [7:0] sh_mask, len_mask;
  logic [63:0] sh_data, rep;
  logic [2:0] size;
  logic ack, any_free, unused_addr;

  assign unused_addr = ^st_addr_i[LW-1:0];

  always_comb begin
    lo = '0;
    for (int i = NB - 1; i >= 0; i--) if (mask_q[i]) lo = LW'(i);
  end

  // chunk is the largest aligned power-of-two block fully enabled at the lowest set byte
  assign sh_mask = 8'(mask_q >> lo);
  assign size = (lo[2:0] == 3'd0 && &sh_mask[7:0]) ? 3'd3 :
                (lo[1:0] == 2'd0 && &sh_mask[3:0]) ? 3'd2 :
                (!lo[0] && &sh_mask[1:0]) ? 3'd1 : 3'd0;
  assign len_mask = size == 3'd3 ? 8'hFF : size == 3'd2 ? 8'h0F : size == 3'd1 ? 8'h03 : 8'h01;
  assign chunk = NB'(len_mask) << lo;
  assign mask_left = mask_q & ~chunk;
  assign sh_data = 64'(data_q >> {lo, 3'b000});
  assign rep = size == 3'd3 ? sh_data :
               size == 3'd2 ? {2{sh_data[31:0]}} :
               size == 3'd1 ? {4{sh_data[15:0]}} : {8{sh_data[7:0]}};

  assign ack = (state == SEND) && req_ack_i;
  assign fre = (rtrn_val_i && rtrn_type_i == 4'b0100) ? (pool_q & (NT'(1) << rtrn_tid_i)) : '0;
  assign ack_bit = ack ? (NT'(1) << tid_q) : '0;
  assign avail = (~pool_q | fre) & ~ack_bit;
  assign any_free = |avail;

  always_comb begin
    nfree = '0;
    for (int i = NT - 1; i >= 0; i--) if (avail[i]) nfree = TID_WIDTH'(i);
  end

  always_comb begin
    state_d = state == IDLE ? ((st_valid_i && (|st_be_i)) ? (any_free ? SEND : WAIT_TID) : IDLE) :
              state == SEND ? (!ack ? SEND : !(|mask_left) ? IDLE : any_free ? SEND : WAIT_TID) :
              state == WAIT_TID ? (any_free ? SEND : WAIT_TID) : IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      base_q <= '0;
      data_q <= '0;
      mask_q <= '0;
      pool_q <= '0;
      tid_q <= '0;
    end else begin
      state <= state_d;
      pool_q <= (pool_q & ~fre) | ack_bit;
      if (state != SEND || ack) tid_q <= nfree;
      if (state == IDLE && st_valid_i) begin
        base_q <= st_addr_i[ADDR_WIDTH-1:LW];
        data_q <= st_data_i;
        mask_q <= st_be_i;
      end else if (ack) begin
        mask_q <= mask_left;
      end
    end
  end

  assign st_ready_o = state == IDLE;
  assign req_val_o = state == SEND;
  assign req_addr_o = req_val_o ? {base_q, lo} : '0;
  assign req_size_o = req_val_o ? size : '0;
  assign req_data_o = req_val_o ? rep : '0;
  assign req_tid_o = req_val_o ? tid_q : '0;
  assign busy_o = (state != IDLE) || (|pool_q);

`ifdef L15_SPLIT_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) stat_pkts_o <= '0;
    else if (ack && !(&stat_pkts_o)) stat_pkts_o <= stat_pkts_o + 32'd1;
  end
`endif
endmodule
